result_streamer: RTL and testbench
==================================

// Module: result_streamer
// PURPOSE
//  Downstream stage of the approximate-multiplier datapath. After the controller finishes
//  writing the 8 products to the output RAM, this block reads them back in address
//  order. It streams them out on a valid/ready interface, buffering through a 2-entry
//  FIFO so that downstream back-pressure never loses a word.
// PARAMETERS
//  DATA_W  32  width of one product word / stream word
//  DEPTH   8   number of words read per run (addresses 0..DEPTH-1)
//  ADDR_W  3   RAM address width; DEPTH <= 2**ADDR_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       one-cycle pulse: begin a run (ignored while busy=1)
//  busy       out  1       high from the cycle after accepted start until the done cycle
//  done       out  1       one-cycle pulse after the last word handshakes
//  ram_rd     out  1       read strobe to output RAM
//  ram_addr   out  ADDR_W  read address
//  ram_rdata  in   DATA_W  RAM read data, valid exactly 1 cycle after ram_rd
//  m_valid    out  1       stream word available
//  m_ready    in   1       downstream accepts; handshake = m_valid & m_ready
//  m_data     out  DATA_W  stream word
//  m_last     out  1       high with the final word (index DEPTH-1)
//  checksum   out  DATA_W  only with RESULT_CHECKSUM_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: busy=0, done=0, ram_rd=0, ram_addr=0, m_valid=0, m_data=0, m_last=0,
//    FIFO empty, read-in-flight flag=0, FSM=IDLE.
//  - FSM states:
//    - IDLE: on start go to READ; clear rd_idx=0 and out_idx=0.
//    - READ: issue reads. Go to DRAIN when rd_idx reaches DEPTH.
//    - DRAIN: wait until out_idx reaches DEPTH (last handshake). Then go to DONE.
//    - DONE: done=1 for one cycle, busy=0. Next cycle go to IDLE.
//  - Read issue:
//    - In READ, assert ram_rd with ram_addr=rd_idx when fifo_count + inflight < 2.
//    - Each read increments rd_idx. At most one read is outstanding.
//    - Result: no more than 2 words are ever owned (stored plus in flight).
//  - Capture: in the cycle after ram_rd, push ram_rdata into the FIFO. The push and a
//    pop in the same cycle are both honoured, and the count is unchanged.
//  - Output:
//    - m_valid = FIFO non-empty. m_data and m_last come from the FIFO head.
//    - With m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays high.
//    - Each handshake pops one entry and increments out_idx.
//  - m_last: high only on the word for which out_idx==DEPTH-1.
//  - Throughput: with m_ready tied high, 1 word/cycle after fill. First m_valid comes
//    2 cycles after start: start, then read addr0, then data pushed.
//  - Full FIFO: no read is issued. ram_addr holds its last value.
//  - start while busy: ignored; no restart, no error flag.
//  - Reset mid-run: all state is cleared at once. Any in-flight RAM data is discarded;
//    it is not pushed.
//  - Counters are ADDR_W+1 bits wide, so DEPTH=2**ADDR_W terminates with no wrap aliasing.
// CONFIGURATION
//  RESULT_CHECKSUM_EN
//    - Defined:
//      - Adds output port checksum[DATA_W-1:0].
//      - checksum is reset to 0 on rst and on each accepted start.
//      - On every handshake, checksum <= checksum + m_data, modulo 2**DATA_W.
//      - The final value is stable from the done cycle until the next start.
//    - Not defined: the port and the adder are absent. All other behaviour is identical.
// TESTING
//  1. RAM = {1,2,...,8}, m_ready=1, pulse start -> m_data 1..8 on consecutive cycles;
//     m_last on 8; done 1 cycle after word 8; busy low in the done cycle.
//  2. Same RAM, m_ready toggles 1,0,1,0 -> every word appears exactly once, in order;
//     data holds during ready=0; ram_rd never issued when count+inflight=2.
//  3. m_ready=0 for 20 cycles after start -> exactly 2 reads issued (addr 0,1);
//     m_data=1 held stable; the rest stream correctly after ready rises.
//  4. start re-pulsed at word 4 -> ignored; the sequence completes with 8 words and
//     one done.
//  5. rst asserted 1 cycle after ram_rd of addr 3 -> all outputs at reset values next
//     cycle; a new start replays the sequence from word 1.
//  6. RESULT_CHECKSUM_EN, RAM = {0xFFFFFFFF,1,0,...,0} -> checksum=0x00000000 at done;
//     RAM = {10,20,...,80} -> checksum=360 (0x168).

Source files
------------

// File: rtl/result_streamer.sv
// Reads DEPTH result words from the output RAM in address order and streams them out through a 2-entry FIFO.
// Optional feature macro: RESULT_CHECKSUM_EN adds a running modular sum of the streamed words.
module result_streamer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] END_IDX  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic [CW-1:0]     out_idx_q, out_idx_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] mem_q [0:1];

  logic issue_s, handshake_s, push_s, pop_s, last_hs_s;

  // A word arriving into an empty FIFO is presented directly, which keeps one word per cycle
  // sustainable while never owning more than two words.
  always_comb begin
    issue_s     = (state_q == S_READ) && (rd_idx_q < END_IDX) &&
                  (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
    m_valid     = (count_q != 2'd0) || inflight_q;
    m_data      = ((count_q == 2'd0) && inflight_q) ? ram_rdata : mem_q[rd_ptr_q];
    m_last      = m_valid && (out_idx_q == LAST_IDX);
    handshake_s = m_valid && m_ready;
    pop_s       = handshake_s && (count_q != 2'd0);
    push_s      = inflight_q && !((count_q == 2'd0) && handshake_s);
    last_hs_s   = handshake_s && (out_idx_q == LAST_IDX);
    ram_rd      = issue_s;
    ram_addr    = issue_s ? rd_idx_q[ADDR_W-1:0] : last_addr_q;
    busy        = (state_q == S_READ) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q + {{(CW-1){1'b0}}, issue_s};
    out_idx_d   = out_idx_q + {{(CW-1){1'b0}}, handshake_s};
    inflight_d  = issue_s;
    last_addr_d = issue_s ? rd_idx_q[ADDR_W-1:0] : last_addr_q;
    wr_ptr_d    = wr_ptr_q ^ push_s;
    rd_ptr_d    = rd_ptr_q ^ pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READ;
          rd_idx_d  = {CW{1'b0}};
          out_idx_d = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (last_hs_s) begin
          state_d = S_DONE;
        end else if (rd_idx_q == END_IDX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (last_hs_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and FIFO storage; reset drops any word still in flight from the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_idx_q    <= {CW{1'b0}};
      out_idx_q   <= {CW{1'b0}};
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      last_addr_q <= {ADDR_W{1'b0}};
      mem_q[0]    <= {DATA_W{1'b0}};
      mem_q[1]    <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      out_idx_q   <= out_idx_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_addr_q <= last_addr_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= ram_rdata;
      end
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running sum of every handshaken word, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= {DATA_W{1'b0}};
    end else if ((state_q == S_IDLE) && start) begin
      checksum_q <= {DATA_W{1'b0}};
    end else if (handshake_s) begin
      checksum_q <= checksum_q + m_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: RAM model, stream monitor and hand-computed expectations.
`timescale 1ns/1ps
module tb_result_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, ram_rd, m_valid, m_ready, m_last;
  logic [2:0]  ram_addr;
  logic [31:0] ram_rdata = 32'h0;
  logic [31:0] m_data;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  result_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef RESULT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mem [0:7];

  logic [31:0] got[$];
  logic        got_last[$];
  int          got_cyc[$];
  int          rd_addrs[$];
  int          rd_cycs[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b0;
  int          owned = 0;
  int          own_err = 0;
  int          hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;

  // RAM model: one-cycle read latency, junk on the bus when no read was issued.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd) ram_rdata <= mem[ram_addr];
    else        ram_rdata <= 32'hDEAD_BEEF;
  end

  // Stream monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      owned = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_data)) hold_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (ram_rd) begin
        if (owned >= 2) own_err++;
        rd_addrs.push_back(int'(ram_addr));
        rd_cycs.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_last.push_back(m_last);
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      owned = owned + (ram_rd ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete(); got_last.delete(); got_cyc.delete();
    rd_addrs.delete(); rd_cycs.delete();
    done_cnt = 0; own_err = 0; hold_err = 0;
  endtask

  // Pulses start for one cycle; returns the cycle number in which start is high.
  task automatic pulse_start(output int k);
    tick();
    start = 1'b1;
    k = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      if (toggle) m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk({tag, "_done_count"}, done_cnt, 1);
  endtask

  task automatic chk_words(input string tag, input logic [31:0] base, input logic [31:0] step);
    int lasts = 0;
    chk({tag, "_word_count"}, got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] obs;
      obs = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
      chk($sformatf("%s_word%0d", tag, i), obs, base + step * i);
    end
    foreach (got_last[i]) if (got_last[i]) lasts++;
    chk({tag, "_last_count"}, lasts, 1);
    chk({tag, "_last_on_final"}, (got_last.size() == 8) ? got_last[7] : 1'bx, 1'b1);
  endtask

  initial begin
    int k;
    int n;
    bit pulsed;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);

    // Reset values
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ram_rd", ram_rd, 1'b0);
    chk("rst_ram_addr", ram_addr, 3'd0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_last", m_last, 1'b0);
`ifdef RESULT_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'h0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // 1: full throughput
    clear_mon();
    pulse_start(k);
    @(negedge clk);
    chk("t1_busy_after_start", busy, 1'b1);
    chk("t1_first_rd", ram_rd, 1'b1);
    chk("t1_first_addr", ram_addr, 3'd0);
    wait_done("t1", 60, 1'b0);
    chk_words("t1", 32'd1, 32'd1);
    chk("t1_first_word_cyc", (got_cyc.size() > 0) ? got_cyc[0] : -1, k + 2);
    chk("t1_last_word_cyc", (got_cyc.size() == 8) ? got_cyc[7] : -1, k + 9);
    chk("t1_done_cyc", done_cyc, k + 10);
    chk("t1_busy_in_done", done_busy, 1'b0);
    chk("t1_own", own_err, 0);

    // 2: ready toggling
    clear_mon();
    pulse_start(k);
    wait_done("t2", 80, 1'b1);
    chk_words("t2", 32'd1, 32'd1);
    chk("t2_hold", hold_err, 0);
    chk("t2_own", own_err, 0);

    // 3: long stall after start
    clear_mon();
    m_ready = 1'b0;
    pulse_start(k);
    repeat (20) tick();
    @(negedge clk);
    chk("t3_reads_during_stall", rd_addrs.size(), 2);
    chk("t3_rd_addr0", (rd_addrs.size() > 0) ? rd_addrs[0] : -1, 0);
    chk("t3_rd_addr1", (rd_addrs.size() > 1) ? rd_addrs[1] : -1, 1);
    chk("t3_valid_held", m_valid, 1'b1);
    chk("t3_data_held", m_data, 32'd1);
    m_ready = 1'b1;
    wait_done("t3", 60, 1'b0);
    chk_words("t3", 32'd1, 32'd1);
    chk("t3_hold", hold_err, 0);

    // 4: start re-pulsed while busy
    clear_mon();
    pulse_start(k);
    n = 0;
    pulsed = 1'b0;
    while (got.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 60, 1'b0);
    repeat (10) tick();
    @(negedge clk);
    chk("t4_single_done", done_cnt, 1);
    chk("t4_idle_after", busy, 1'b0);
    chk_words("t4", 32'd1, 32'd1);

    // 5: reset one cycle after the read of address 3
    clear_mon();
    pulse_start(k);
    n = 0;
    while (rd_addrs.size() < 4 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_saw_rd3", (rd_addrs.size() >= 4) ? rd_addrs[3] : -1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_ram_rd", ram_rd, 1'b0);
    chk("t5_ram_addr", ram_addr, 3'd0);
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_m_data", m_data, 32'h0);
    chk("t5_m_last", m_last, 1'b0);
    repeat (3) tick();
    clear_mon();
    pulse_start(k);
    wait_done("t5", 60, 1'b0);
    chk_words("t5", 32'd1, 32'd1);

`ifdef RESULT_CHECKSUM_EN
    // 6: checksum wrap and plain sum
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1;
    for (int i = 2; i < 8; i++) mem[i] = 32'd0;
    clear_mon();
    pulse_start(k);
    wait_done("t6a", 60, 1'b0);
    chk("t6_checksum_wrap", checksum, 32'h0000_0000);
    for (int i = 0; i < 8; i++) mem[i] = 32'(10 * (i + 1));
    clear_mon();
    pulse_start(k);
    wait_done("t6b", 60, 1'b0);
    chk("t6_checksum_sum", checksum, 32'd360);
    chk_words("t6b", 32'd10, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
